// File: rtl/phase_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : phase_sequencer
// Purpose  : Multicycle phase generator for the instruction decoder/control
//            unit. It idles after reset and starts on a rising edge of run_i.
//            In RUN it cycles phase 1..5 once per instruction. It drops to
//            phase 0 and latches HALT when the control unit raises hlt_i.
// Optional : `define PHASE_STEP_EN enables single-step mode. In that mode the
//            sequencer pauses after each instruction while step_mode_i is set,
//            and each rising edge of step_i executes one more instruction.
//            When the macro is undefined, step_mode_i and step_i are ignored.
// Ports    : clk          - system clock, rising edge
//            rst          - asynchronous active-high reset
//            run_i        - start request (level, rising-edge detected)
//            step_mode_i  - single-step enable (level)
//            step_i       - step request (level, rising-edge detected)
//            hlt_i        - halt request from the control unit
//            phase_o      - 0 inactive, 1 fetch, 2 decode, 3 exec, 4 mem, 5 wb
//            running_o    - state is RUN
//            halted_o     - state is HALT
//            instr_cnt_o  - instructions completed through phase 5
// Revision : 1.0 - initial release
// ============================================================================
module phase_sequencer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run_i,
  input  logic             step_mode_i,
  input  logic             step_i,
  input  logic             hlt_i,
  output logic [2:0]       phase_o,
  output logic             running_o,
  output logic             halted_o,
  output logic [CNT_W-1:0] instr_cnt_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_HALT  = 2'd2,
    S_PAUSE = 2'd3
  } state_t;

  localparam logic [2:0]       PH_IDLE  = 3'd0;
  localparam logic [2:0]       PH_FETCH = 3'd1;
  localparam logic [2:0]       PH_WB    = 3'd5;
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [2:0]       phase_q, phase_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             run_q;
  logic             step_q;
  logic             run_rise;
  logic             step_rise;

  assign run_rise  = run_i & ~run_q;
  assign step_rise = step_i & ~step_q;

`ifndef PHASE_STEP_EN
  // Step inputs remain on the port list but have no effect in this build.
  logic unused_step_inputs;
  assign unused_step_inputs = step_mode_i ^ step_rise;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      phase_q <= PH_IDLE;
      cnt_q   <= '0;
      run_q   <= 1'b0;
      step_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      run_q   <= run_i;
      step_q  <= step_i;
    end
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    cnt_d   = cnt_q;

    case (state_q)
      S_RUN: begin
        // A halt abandons the current phase and retires nothing, including
        // in write-back. run_rise has no effect while running.
        if (hlt_i) begin
          state_d = S_HALT;
          phase_d = PH_IDLE;
        end else if (phase_q == PH_WB) begin
          cnt_d = cnt_q + CNT_ONE;
`ifdef PHASE_STEP_EN
          if (step_mode_i) begin
            state_d = S_PAUSE;
            phase_d = PH_IDLE;
          end else begin
            phase_d = PH_FETCH;
          end
`else
          phase_d = PH_FETCH;
`endif
        end else begin
          phase_d = phase_q + 3'd1;
        end
      end

      S_PAUSE: begin
`ifdef PHASE_STEP_EN
        // Leave the pause on a step pulse, on a run pulse, or when
        // step_mode is dropped (resume free-running).
        if (run_rise || step_rise || !step_mode_i) begin
          state_d = S_RUN;
          phase_d = PH_FETCH;
        end
`else
        if (run_rise) begin
          state_d = S_RUN;
          phase_d = PH_FETCH;
        end
`endif
      end

      default: begin
        // IDLE and HALT: hlt_i is ignored at phase 0; only a new run pulse
        // starts execution.
        if (run_rise) begin
          state_d = S_RUN;
          phase_d = PH_FETCH;
        end
      end
    endcase
  end

  assign phase_o     = phase_q;
  assign running_o   = (state_q == S_RUN);
  assign halted_o    = (state_q == S_HALT);
  assign instr_cnt_o = cnt_q;

endmodule
`default_nettype wire

// File: doc/phase_sequencer.md
# phase_sequencer

Multicycle phase generator that produces the 3-bit `phase` consumed by the instruction decoder/control unit and reacts to its `hlt` output. It holds the processor idle after reset, starts execution on a run request and cycles phases 1→5 once per instruction. It returns to phase 0 and latches a halted state when the control unit asserts `hlt`. An optional single-step mode pauses after every instruction.

## Interface
- `CNT_W`, 16, width of the retired-instruction counter
- `clk`  in  1  system clock; all state updates on its rising edge
- `rst`  in  1  asynchronous, active-high reset
- `run`  in  1  start request (level, synchronous); internally rising-edge detected
- `step_mode`  in  1  single-step enable (level); used only with `PHASE_STEP_EN`
- `step`  in  1  step request (level); internally rising-edge detected; used only with `PHASE_STEP_EN`
- `hlt`  in  1  halt request from the control unit, combinational from the current phase/instruction
- `phase`  out  3  current phase: 0 = inactive, 1 = fetch, 2 = decode/register read, 3 = execute, 4 = memory, 5 = write-back
- `running`  out  1  high in state RUN
- `halted`  out  1  high in state HALT
- `instr_cnt`  out  CNT_W  number of instructions completed through phase 5

## Operation
- States:
  - IDLE: after reset, phase 0.
  - RUN: phase 1..5.
  - HALT: phase 0, set by `hlt`.
  - PAUSE: phase 0, between single steps.
- Edge detect: `run_rise = run & ~run_q` and `step_rise = step & ~step_q`. `run_q` and `step_q` are registered and cleared by reset.
- IDLE, HALT or PAUSE plus `run_rise` → RUN, phase 1. HALT is left only via `run_rise` or `rst`.
- `run_rise` while in RUN is ignored.
- RUN: phase advances 1→2→3→4→5→1.
  - At the 5→next edge, `instr_cnt` += 1, wrapping modulo 2^CNT_W.
  - `hlt` sampled high at an edge with phase ∈ {1..5} → HALT, phase 0. The current phase is abandoned and `instr_cnt` is not incremented, even in phase 5.
- Priority at the same edge: `rst` > `hlt` > step-mode pause > normal advance.
- `hlt` is ignored while phase = 0.
- Outputs are registered; `running` and `halted` are decoded from the state register.
- The counter holds its value in IDLE, HALT and PAUSE. It is cleared only by `rst`.

## Timing
- Reset values: `phase` = 0, `running` = 0, `halted` = 0, `instr_cnt` = 0, state = IDLE.
- Reset asserted mid-instruction forces these values immediately, without waiting for a clock edge.
- Start latency:
  - `run` rises before edge N; `phase` = 1 after edge N.
  - Phase 5 is reached after edge N+4.
  - The next phase 1 begins after edge N+5.
- Throughput: one instruction per 5 clocks in RUN.
- Halt: `hlt` high before edge M in RUN → `phase` = 0 and `halted` = 1 after edge M. `running` falls at the same edge.
- `run` held high continuously produces only one start. A new start requires `run` to go low for at least one cycle.

## Configuration
- `PHASE_STEP_EN` defined:
  - In RUN with `step_mode` = 1, the edge leaving phase 5 increments `instr_cnt` and enters PAUSE (phase 0) instead of phase 1.
  - PAUSE plus `step_rise` → phase 1, executing exactly one instruction.
  - PAUSE with `step_mode` = 0 at an edge → phase 1, resuming free-running.
  - `hlt` still wins over pause.
- `PHASE_STEP_EN` not defined:
  - `step_mode` and `step` are ignored (ports remain).
  - PAUSE is unreachable; phase 5 always advances to phase 1.

## Test plan
- Start: reset, `run` pulsed 1 cycle → `phase` sequence 1,2,3,4,5,1,2; `instr_cnt` = 1 after the first phase 5; `running` = 1.
- Halt: `hlt` forced high during the 3rd instruction's phase 2 → next cycle `phase` = 0, `halted` = 1, `instr_cnt` = 2. Further `hlt` pulses cause no change.
- Halt in phase 5 plus simultaneous `run_rise` → HALT taken, `instr_cnt` not incremented. A later `run` pulse restarts at phase 1.
- Reset mid-run: `rst` asserted asynchronously in phase 4 → outputs 0 before the next edge; after release, remains IDLE until `run` is pulsed.
- Counter wrap: CNT_W = 4, 17 instructions run → `instr_cnt` = 1.
- With `PHASE_STEP_EN`, `step_mode` = 1: after `run`, one instruction, then `phase` held at 0 for 10 cycles. Each `step` pulse yields phases 1..5 and +1 count. Clearing `step_mode` resumes continuous cycling.
